mem_arbiter: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/mem_arbiter_starve_ctr.sv | 37 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Encoded so the state register doubles as the gnt output.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of data grants taken while instruction fetch was waiting.
module starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With STARVE_MAX=0 this is constantly true, so instruction always wins ties.
  assign at_max = (cnt_q >= MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Registered-grant arbiter sharing one RAM port between instruction and data requesters.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [1:0]  gnt,
  output logic        ram_err
);

  arb_state_t state_q, state_d;
  logic       ram_err_q, ram_err_d;
  logic       cnt_inc, cnt_clr, at_max;
  logic       d_req, ram_done, ram_fail;
  ramstate_t  rs;

  starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .CLK    (CLK),
    .nRST   (nRST),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .at_max (at_max)
  );

  assign rs       = ramstate_t'(ramstate);
  assign ram_fail = (rs == ERROR);
  assign ram_done = (rs == ACCESS) || ram_fail;
  assign d_req    = dREN | dWEN;

  always_comb begin
    state_d   = state_q;
    ram_err_d = ram_err_q;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iload     = '0;
    dload     = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;

    case (state_q)
      IDLE: begin
        if (d_req && (!iREN || !at_max)) begin
          state_d = SERVE_D;
          cnt_inc = iREN;
          cnt_clr = !iREN;
        end else if (iREN) begin
          state_d = SERVE_I;
          cnt_clr = 1'b1;
        end
      end

      SERVE_I: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = ramload;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_done) begin
          iwait   = 1'b0;
          state_d = IDLE;
          if (ram_fail) ram_err_d = 1'b1;
        end
      end

      SERVE_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = ramload;
        if (!d_req) begin
          state_d = IDLE;
        end else if (ram_done) begin
          dwait   = 1'b0;
          state_d = IDLE;
          if (ram_fail) ram_err_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      ram_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ram_err_q <= ram_err_d;
    end
  end

  assign gnt     = state_q;
  assign ram_err = ram_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a completion scoreboard and a combinational RAM stub.
module tb_mem_arbiter;

  localparam int SM = 2;
  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_I    = 2'b01;
  localparam logic [1:0] G_D    = 2'b10;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, iload, dload;
  logic        iwait, dwait;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  rstate, gnt;
  logic        ram_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  g;
    logic [31:0] a;
    logic [31:0] d;
    logic        wr;
  } exp_t;
  exp_t sb[$];

  mem_arbiter #(.STARVE_MAX(SM)) u_dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (rstate),
    .gnt      (gnt),
    .ram_err  (ram_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign ramload = model_rd(ramaddr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_txn(input logic [1:0] g, input logic [31:0] a,
                            input logic [31:0] d, input logic wr);
    exp_t e;
    e.g = g; e.a = a; e.d = d; e.wr = wr;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  // Every completion pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST && (!iwait || !dwait)) begin
      chk("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("done_gnt", 32'(gnt), 32'(e.g));
        chk("done_wait", 32'({iwait, dwait}), (e.g == G_I) ? 32'd1 : 32'd2);
        chk("done_addr", ramaddr, e.a);
        chk("done_wen", 32'(ramWEN), 32'(e.wr));
        if (e.wr) chk("done_store", ramstore, e.d);
        else      chk("done_load", (e.g == G_D) ? dload : iload, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; rstate = RS_FREE;
    #1;
    chk("rst_gnt", 32'(gnt), 32'(G_NONE));
    chk("rst_ramren", 32'(ramREN), 0);
    chk("rst_ramwen", 32'(ramWEN), 0);
    chk("rst_iwait", 32'(iwait), 1);
    chk("rst_dwait", 32'(dwait), 1);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_err", 32'(ram_err), 0);
    tick(); tick();
    nRST = 1'b1;

    // Instruction-only fetch, zero-latency RAM
    iREN = 1'b1; iaddr = 32'h40; rstate = RS_ACCESS;
    mid();
    chk("t1_idle_gnt", 32'(gnt), 32'(G_NONE));
    chk("t1_idle_ren", 32'(ramREN), 0);
    expect_txn(G_I, 32'h40, 32'h8C22_0004, 1'b0);
    tick(); mid();
    chk("t1_ren", 32'(ramREN), 1);
    chk("t1_addr", ramaddr, 32'h40);
    chk("t1_gnt", 32'(gnt), 32'(G_I));
    chk("t1_iwait", 32'(iwait), 0);
    chk("t1_iload", iload, 32'h8C22_0004);
    tick(); iREN = 1'b0; mid();
    chk("t1_after_gnt", 32'(gnt), 32'(G_NONE));

    // Simultaneous requests, counter at zero: data first
    tick();
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h100; iaddr = 32'h44;
    mid();
    expect_txn(G_D, 32'h100, model_rd(32'h100), 1'b0);
    tick(); mid();
    chk("t2_gnt_d", 32'(gnt), 32'(G_D));
    chk("t2_addr_d", ramaddr, 32'h100);
    tick(); dREN = 1'b0; mid();
    chk("t2_idle", 32'(gnt), 32'(G_NONE));
    expect_txn(G_I, 32'h44, model_rd(32'h44), 1'b0);
    tick(); mid();
    chk("t2_gnt_i", 32'(gnt), 32'(G_I));
    chk("t2_addr_i", ramaddr, 32'h44);
    tick(); iREN = 1'b0; mid();
    chk("t2_after", 32'(gnt), 32'(G_NONE));

    // Both held, STARVE_MAX=2: D, D, I, D, D, I with IDLE between grants
    tick();
    iREN = 1'b1; dREN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k % 3 == 2) expect_txn(G_I, 32'h44, model_rd(32'h44), 1'b0);
      else            expect_txn(G_D, 32'h100, model_rd(32'h100), 1'b0);
    end
    for (int c = 0; c < 12; c++) begin
      mid();
      chk("t3_gnt", 32'(gnt),
          (c % 2 == 0) ? 32'(G_NONE) : (((c / 2) % 3 == 2) ? 32'(G_I) : 32'(G_D)));
      tick();
    end
    iREN = 1'b0; dREN = 1'b0;
    mid();
    chk("t3_after", 32'(gnt), 32'(G_NONE));

    // Write with three BUSY cycles; write wins over a simultaneous read
    tick();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; rstate = RS_BUSY;
    mid();
    expect_txn(G_D, 32'h200, 32'hDEAD_BEEF, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) rstate = RS_ACCESS;
      mid();
      chk("t4_wen", 32'(ramWEN), 1);
      chk("t4_ren", 32'(ramREN), 0);
      chk("t4_addr", ramaddr, 32'h200);
      chk("t4_store", ramstore, 32'hDEAD_BEEF);
      chk("t4_dwait", 32'(dwait), (k == 3) ? 32'd0 : 32'd1);
      tick();
    end
    dREN = 1'b0; dWEN = 1'b0;

    // Abort during BUSY: no completion pulse
    dREN = 1'b1; daddr = 32'h300; rstate = RS_BUSY;
    mid();
    chk("t5_idle", 32'(gnt), 32'(G_NONE));
    tick(); mid();
    chk("t5_ren", 32'(ramREN), 1);
    chk("t5_dwait", 32'(dwait), 1);
    tick(); dREN = 1'b0; mid();
    chk("t5_abort_ren", 32'(ramREN), 0);
    chk("t5_abort_dwait", 32'(dwait), 1);
    tick(); mid();
    chk("t5_abort_idle", 32'(gnt), 32'(G_NONE));
    chk("t5_err_clear", 32'(ram_err), 0);

    // ERROR completion sets the sticky flag
    tick();
    dREN = 1'b1; daddr = 32'h304; rstate = RS_ERROR;
    mid();
    expect_txn(G_D, 32'h304, model_rd(32'h304), 1'b0);
    tick(); mid();
    chk("t5_err_dwait", 32'(dwait), 0);
    chk("t5_err_pre", 32'(ram_err), 0);
    tick(); dREN = 1'b0; rstate = RS_FREE; mid();
    chk("t5_err_set", 32'(ram_err), 1);
    tick(); tick(); mid();
    chk("t5_err_sticky", 32'(ram_err), 1);

    // Asynchronous reset in the middle of a data service
    tick();
    dREN = 1'b1; daddr = 32'h400; rstate = RS_BUSY;
    mid(); tick(); mid();
    chk("t6_pre_ren", 32'(ramREN), 1);
    chk("t6_pre_gnt", 32'(gnt), 32'(G_D));
    #2 nRST = 1'b0;
    #1;
    chk("t6_rst_ren", 32'(ramREN), 0);
    chk("t6_rst_wen", 32'(ramWEN), 0);
    chk("t6_rst_gnt", 32'(gnt), 32'(G_NONE));
    chk("t6_rst_dwait", 32'(dwait), 1);
    chk("t6_rst_err", 32'(ram_err), 0);
    tick();
    nRST = 1'b1; dREN = 1'b0; iREN = 1'b1; iaddr = 32'h48; rstate = RS_ACCESS;
    mid();
    chk("t6_idle", 32'(gnt), 32'(G_NONE));
    expect_txn(G_I, 32'h48, model_rd(32'h48), 1'b0);
    tick(); mid();
    chk("t6_gnt_i", 32'(gnt), 32'(G_I));
    chk("t6_iwait", 32'(iwait), 0);
    tick(); iREN = 1'b0; mid();
    chk("t6_after", 32'(gnt), 32'(G_NONE));

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
